// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator with one shared period counter.
//
// Purpose:
//   CHANNELS independent PWM outputs share one period counter. The period
//   is programmable through a top value. Duty and top updates are written
//   into shadow registers. They move to the active registers only at a
//   period boundary, or at once while the bank is disabled, so an output
//   never glitches in the middle of a period.
//
// Parameters:
//   WIDTH    - bit width of the counter, the top value and each duty level
//   CHANNELS - number of PWM outputs
//
// Ports:
//   clk            - clock, all logic on the rising edge
//   reset          - asynchronous, active-low reset
//   en             - run enable; 0 holds the counter at 0 and forces outputs low
//   load           - one-cycle strobe that captures level/top into the shadow
//   level          - packed duties, channel i = level[i*WIDTH +: WIDTH]
//   top            - period top value (edge mode period = top+1 cycles)
//   center         - (optional) centre-aligned mode select, shadowed like top
//   out            - registered PWM outputs
//   period_start   - one-cycle pulse aligned with the first out cycle of a period
//   update_pending - shadow holds values not yet applied
//
// Optional feature:
//   PWM_BANK_CENTER_ALIGN_EN - when defined, adds the 'center' input and the
//   up/down counting mode. The up/down counting mode needs a direction
//   register. When the macro is undefined, the bank runs in edge mode only.

module pwm_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      load,
  input  logic [CHANNELS*WIDTH-1:0] level,
  input  logic [WIDTH-1:0]          top,
`ifdef PWM_BANK_CENTER_ALIGN_EN
  input  logic                      center,
`endif
  output logic [CHANNELS-1:0]       out,
  output logic                      period_start,
  output logic                      update_pending
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    top_sh_q, top_act_q;
  logic                pending_q, pending_d;
  logic [CHANNELS-1:0] out_q, out_d;
  logic                period_start_q, period_start_d;
  logic                boundary;
  logic                apply;
  logic                wrap;

  logic [WIDTH-1:0] duty_sh_q  [CHANNELS];
  logic [WIDTH-1:0] duty_act_q [CHANNELS];

`ifdef PWM_BANK_CENTER_ALIGN_EN
  logic center_sh_q, center_act_q;
  logic dir_q, dir_d;   // 1 while counting down

  // In centre mode the last cycle of a period is the cycle that returns to 0.
  // That cycle is cnt==1 on the way down, which includes the turn-around cycle
  // when top_act==1. When top_act==0, every cycle is a boundary.
  assign wrap = center_act_q
              ? ((top_act_q == '0) ||
                 ((dir_q || (cnt_q == top_act_q)) && (cnt_q == CNT_ONE)))
              : (cnt_q == top_act_q);
`else
  assign wrap = (cnt_q == top_act_q);
`endif

  assign boundary = en && wrap;
  // Shadow values reach the active set at a boundary, and on every cycle
  // while the bank is disabled.
  assign apply    = !en || boundary;

  always_comb begin
    pending_d = pending_q;
    if (apply) begin
      pending_d = 1'b0;           // a load on an apply cycle writes straight through
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
`ifdef PWM_BANK_CENTER_ALIGN_EN
    dir_d = dir_q;
    if (apply) begin
      cnt_d = '0;
      dir_d = 1'b0;
    end else if (center_act_q) begin
      if (dir_q) begin
        cnt_d = cnt_q - CNT_ONE;
      end else if (cnt_q == top_act_q) begin
        cnt_d = cnt_q - CNT_ONE;  // turn around at the top
        dir_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
`else
    if (apply) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
`endif
  end

  assign period_start_d = en && (cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q          <= '0;
      top_sh_q       <= '1;
      top_act_q      <= '1;
      pending_q      <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      period_start_q <= period_start_d;
      if (load) begin
        top_sh_q <= top;
      end
      if (apply) begin
        if (load) begin
          top_act_q <= top;       // bypass the shadow on an apply cycle
        end else if (pending_q) begin
          top_act_q <= top_sh_q;
        end
      end
    end
  end

`ifdef PWM_BANK_CENTER_ALIGN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_q        <= 1'b0;
      center_sh_q  <= 1'b0;
      center_act_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
      if (load) begin
        center_sh_q <= center;
      end
      if (apply) begin
        if (load) begin
          center_act_q <= center;
        end else if (pending_q) begin
          center_act_q <= center_sh_q;
        end
      end
    end
  end
`endif

  // Per-channel duty registers and compare.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [WIDTH-1:0] level_ch;
      assign level_ch  = level[gi*WIDTH +: WIDTH];
      assign out_d[gi] = en && (cnt_q < duty_act_q[gi]);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          duty_sh_q[gi]  <= '0;
          duty_act_q[gi] <= '0;
          out_q[gi]      <= 1'b0;
        end else begin
          out_q[gi] <= out_d[gi];
          if (load) begin
            duty_sh_q[gi] <= level_ch;
          end
          if (apply) begin
            if (load) begin
              duty_act_q[gi] <= level_ch;
            end else if (pending_q) begin
              duty_act_q[gi] <= duty_sh_q[gi];
            end
          end
        end
      end
    end
  endgenerate

  assign out            = out_q;
  assign period_start   = period_start_q;
  assign update_pending = pending_q;

endmodule

// File: doc/pwm_bank.md
Name: pwm_bank

Overview:
- Multi-channel, parametrised successor to the single 8-bit PWM used for the RGB mixer.
- N channels share one period counter with a programmable period (top value).
- Duty and period updates are double-buffered and take effect only at period boundaries, so outputs never glitch mid-period.
- Registered outputs drive LED pins directly; one instance serves all colour channels.

Parameters:
- WIDTH, 8, bit width of counter, top and each duty level.
- CHANNELS, 3, number of independent PWM outputs.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low. reset=0 immediately clears all state; deassertion is sampled by clk.
- en  input  1  run enable. 0 stops the counter and forces outputs low.
- load  input  1  one-cycle strobe that captures level and top into the shadow registers.
- level  input  CHANNELS*WIDTH  packed duty values; channel i is level[i*WIDTH +: WIDTH].
- top  input  WIDTH  period top value; period = top+1 cycles (edge mode).
- out  output  CHANNELS  registered PWM outputs.
- period_start  output  1  one-cycle pulse aligned with the first out cycle of each period.
- update_pending  output  1  high while the shadow holds values not yet applied.

Behaviour:
- Reset values: cnt=0, out=0, period_start=0, update_pending=0, all shadow and active duties=0, shadow and active top = all-ones.
- Counter (edge mode): cnt counts 0..top_act, then wraps to 0. Boundary cycle = en && cnt==top_act.
- top_act=0 gives a 1-cycle period with a boundary every cycle.
- Compare: out[i] <= en && (cnt < duty_act[i]). This is one cycle of latency from cnt to pin.
- Compare is unsigned at WIDTH bits; no overflow is possible.
- Duty boundary cases:
  - duty=0: constantly low.
  - duty >= top_act+1: constantly high.
  - Otherwise exactly duty high cycles per period, high first.
- period_start <= en && cnt==0. It is registered, so it coincides with out for cnt=0.
- Load:
  - load=1 latches level into duty_sh and top into top_sh, and sets update_pending=1.
  - Repeated loads before a boundary overwrite the shadow; last one wins.
- Transfer: on a boundary cycle with update_pending=1, duty_act<=duty_sh, top_act<=top_sh, and update_pending<=0.
  - The new values govern the period starting next cycle.
- load on a boundary cycle: the level/top presented that cycle bypass the shadow and go straight to active for the next period. Shadow is also written; update_pending ends 0.
- en=0:
  - cnt held at 0, out=0, period_start=0.
  - Pending shadow transferred to active every cycle, so update_pending=0 (a load still writes through).
  - Period restarts at cnt=0 on the first cycle en=1.
- en deasserted mid-period: outputs go low on the next cycle; counter is abandoned, not completed.
- Reset asserted mid-operation: all outputs low asynchronously; no partial transfer survives.

Optional Feature:
- Macro: PWM_BANK_CENTER_ALIGN_EN.
- With the macro defined:
  - Adds input port center (1 bit), sampled only at boundaries or when en=0; it is double-buffered like top.
  - center_act=1 selects up/down counting: 0,1,..,top_act,top_act-1,..,1, then back to 0. Period = 2*top_act cycles; top_act=0 gives period 1.
  - Boundary = cycle where cnt==1 while counting down (or cnt==0 when top_act=0).
  - Compare rule and period_start (cnt==0) are unchanged.
  - The high pulse is symmetric about cnt=0.
- Without the macro: no center port, edge mode only, and the direction register is not built.

Test Plan:
- Async reset: run with top=9 and levels 3/5/7, pull reset low between edges -> out=000, period_start=0, update_pending=0 immediately, before the next clk edge.
- Basic duties: WIDTH=8, CHANNELS=3, load top=9 with levels 0/5/10, en=1 -> ch0 always 0, ch1 5 high of 10, ch2 always 1; period_start every 10 cycles.
- Mid-period update: during cnt=3, load ch1 level=2 -> update_pending=1; current period keeps 5 high cycles, next period has 2; pending clears at cnt==9.
- Load on boundary: load top=3 and ch0=1 in the cnt==9 cycle -> next period is 4 cycles with ch0 high 1 cycle; update_pending stays 0.
- Disable/re-enable: en=0 at cnt=6 -> out=000 next cycle; load while disabled applies immediately; en=1 -> period_start on the first output cycle, cnt starts at 0.
- Center mode (macro on): center=1, top=4, ch0=2 -> cnt sequence 0,1,2,3,4,3,2,1, period 8, out high for cnt 0,1 and the down-count 1 -> 3 of 8 cycles.
